serial_adder_ctrl: RTL

Bit-serial multi-bit adder that time-shares a single 1-bit `Full_Adder` cell across WIDTH cycles. A start/done handshake accepts two WIDTH-bit operands and a carry-in. An internal FSM shifts the operands LSB-first through the cell and holds the carry between cycles in a flop. It then presents the registered sum and carry-out. It is the sequencing controller for the lab's full-adder datapath and provides an area-minimal alternative to a ripple-carry adder.

---
 rtl/serial_adder_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell processes two WIDTH-bit operands
// LSB-first over WIDTH cycles under a start/busy/done handshake.

module Full_Adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
         $error("serial_adder_ctrl: WIDTH must be in 1..32");
      end
   endgenerate

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sa_nxt;
   logic [WIDTH-1:0] sb, sb_nxt;
   logic [WIDTH-1:0] ps, ps_nxt;
   logic [WIDTH-1:0] ps_shift;
   logic [WIDTH-1:0] sum_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             c, c_nxt;
   logic             cout_nxt;
   logic             fa_s, fa_co;

   Full_Adder u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (c),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_ps_one
         assign ps_shift = fa_s;
      end else begin : g_ps_many
         assign ps_shift = {fa_s, ps[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         ps    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         sa    <= sa_nxt;
         sb    <= sb_nxt;
         ps    <= ps_nxt;
         c     <= c_nxt;
         cnt   <= cnt_nxt;
         sum   <= sum_nxt;
         cout  <= cout_nxt;
         // Flags mirror the next state so they equal a decode of the registered state.
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt = state;
      sa_nxt    = sa;
      sb_nxt    = sb;
      ps_nxt    = ps;
      c_nxt     = c;
      cnt_nxt   = cnt;
      sum_nxt   = sum;
      cout_nxt  = cout;

      case (state)
         IDLE: begin
            if (start) begin
               sa_nxt    = a;
               sb_nxt    = b;
               c_nxt     = cin;
               ps_nxt    = '0;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            sa_nxt  = sa >> 1;
            sb_nxt  = sb >> 1;
            ps_nxt  = ps_shift;
            c_nxt   = fa_co;
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               sum_nxt   = ps_shift;
               cout_nxt  = fa_co;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Handshake sanity: flags are exclusive and done never lasts more than one cycle.
   a_flags_excl : assert property (@(posedge clk) disable iff (rst) !(busy && done));
   a_done_pulse : assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
